// File: rtl/pc_stack_if.sv
// Control-unit <-> program-counter bus: operation select, branch/call operands,
// and the PC, return-stack level and error status reported back.
interface pc_stack_if #(
  parameter int unsigned ADDR_SIZE   = 14,
  parameter int unsigned STACK_DEPTH = 8
);
  localparam int unsigned LVL_SIZE = $clog2(STACK_DEPTH + 1);

  logic [2:0]           sel;
  logic                 cond;
  logic [ADDR_SIZE-1:0] target;
  logic [ADDR_SIZE-1:0] offset;
  logic                 err_clr;
  logic [ADDR_SIZE-1:0] pc;
  logic [LVL_SIZE-1:0]  level;
  logic                 stack_full;
  logic                 stack_empty;
  logic                 overflow_err;
  logic                 underflow_err;

  modport master (
    output sel, cond, target, offset, err_clr,
    input  pc, level, stack_full, stack_empty, overflow_err, underflow_err
  );

  modport slave (
    input  sel, cond, target, offset, err_clr,
    output pc, level, stack_full, stack_empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/pc_stack.sv
// Fetch-stage program counter with PC-relative branch, call/return through an
// internal return-address stack, stack level visibility and sticky error flags.
module pc_stack #(
  parameter int unsigned ADDR_SIZE   = 14,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned RESET_ADDR  = 0
) (
  input logic       clk,
  input logic       rst,
  pc_stack_if.slave bus
);
  localparam int unsigned LVL_SIZE = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_SIZE = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_KEEP   = 3'd1,
    OP_LOAD   = 3'd2,
    OP_BRANCH = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } op_e;

  logic [ADDR_SIZE-1:0] ras [STACK_DEPTH];
  logic [ADDR_SIZE-1:0] pc_q;
  logic [LVL_SIZE-1:0]  lvl_q;
  logic                 ovf_q;
  logic                 udf_q;

  op_e                  op;
  logic [ADDR_SIZE-1:0] pc_inc;
  logic [ADDR_SIZE-1:0] pc_rel;
  logic                 full;
  logic                 empty;
  logic                 do_push;
  logic                 do_pop;
  logic                 ovf_evt;
  logic                 udf_evt;
  logic [IDX_SIZE-1:0]  push_idx;
  logic [IDX_SIZE-1:0]  pop_idx;

  always_comb begin
    op       = op_e'(bus.sel);
    pc_inc   = pc_q + ADDR_SIZE'(1);
    pc_rel   = pc_q + bus.offset;
    full     = (lvl_q == LVL_SIZE'(STACK_DEPTH));
    empty    = (lvl_q == '0);
    do_push  = (op == OP_CALL) && !full;
    do_pop   = (op == OP_RET) && !empty;
    ovf_evt  = (op == OP_CALL) && full;
    udf_evt  = (op == OP_RET) && empty;
    // Indices are only used when the matching push/pop is legal, so the
    // truncation never aliases a valid entry.
    push_idx = IDX_SIZE'(lvl_q);
    pop_idx  = IDX_SIZE'(lvl_q - LVL_SIZE'(1));
  end

  // Storage is deliberately not reset; level alone defines validity.
  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      ras[push_idx] <= pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= ADDR_SIZE'(RESET_ADDR);
      lvl_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      unique case (op)
        OP_NEXT:   pc_q <= pc_inc;
        OP_LOAD:   pc_q <= bus.target;
        OP_BRANCH: pc_q <= bus.cond ? pc_rel : pc_inc;
        OP_CALL: begin
          if (do_push) begin
            pc_q  <= bus.target;
            lvl_q <= lvl_q + LVL_SIZE'(1);
          end
        end
        OP_RET: begin
          if (do_pop) begin
            pc_q  <= ras[pop_idx];
            lvl_q <= lvl_q - LVL_SIZE'(1);
          end
        end
        default: pc_q <= pc_q;
      endcase

      // A new error event on the same edge beats the clear.
      if (ovf_evt)          ovf_q <= 1'b1;
      else if (bus.err_clr) ovf_q <= 1'b0;
      if (udf_evt)          udf_q <= 1'b1;
      else if (bus.err_clr) udf_q <= 1'b0;
    end
  end

  always_comb begin
    bus.pc            = pc_q;
    bus.level         = lvl_q;
    bus.stack_full    = full;
    bus.stack_empty   = empty;
    bus.overflow_err  = ovf_q;
    bus.underflow_err = udf_q;
  end
endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: sequential ops, branch/wrap arithmetic, nested
// call/return, overflow/underflow flags and reset during a call sequence.
module tb_pc_stack;
  logic clk = 1'b0;
  logic rst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [2:0] NEXT = 3'd0, KEEP = 3'd1, LOAD = 3'd2, BRANCH = 3'd3,
                         CALL = 3'd4, RET = 3'd5;

  pc_stack_if #(.ADDR_SIZE(14), .STACK_DEPTH(8)) bus ();

  pc_stack #(.ADDR_SIZE(14), .STACK_DEPTH(8), .RESET_ADDR(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pl(input string tag, input int unsigned exp_pc, input int unsigned exp_lvl);
    chk({tag, ".pc"}, 32'(bus.pc), exp_pc);
    chk({tag, ".level"}, 32'(bus.level), exp_lvl);
  endtask

  task automatic op(input logic [2:0] s, input logic [13:0] tgt);
    bus.sel    = s;
    bus.target = tgt;
    step();
  endtask

  initial begin
    rst         = 1'b0;
    bus.sel     = NEXT;
    bus.cond    = 1'b0;
    bus.target  = '0;
    bus.offset  = '0;
    bus.err_clr = 1'b0;

    step();
    step();
    chk_pl("reset", 0, 0);
    chk("reset.empty", 32'(bus.stack_empty), 1);
    chk("reset.full", 32'(bus.stack_full), 0);
    chk("reset.ovf", 32'(bus.overflow_err), 0);
    chk("reset.udf", 32'(bus.underflow_err), 0);

    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      op(NEXT, 14'h0);
      chk("next.pc", 32'(bus.pc), 32'(i));
    end

    op(LOAD, 14'd10);
    chk("load.pc", 32'(bus.pc), 10);
    bus.offset = 14'h3FFD;
    bus.cond   = 1'b1;
    op(BRANCH, 14'h0);
    chk("branch_taken.pc", 32'(bus.pc), 7);
    bus.cond = 1'b0;
    op(BRANCH, 14'h0);
    chk("branch_not.pc", 32'(bus.pc), 8);
    op(LOAD, 14'h3FFF);
    op(NEXT, 14'h0);
    chk("next_wrap.pc", 32'(bus.pc), 0);
    bus.offset = 14'h3FFF;
    bus.cond   = 1'b1;
    op(BRANCH, 14'h0);
    chk("branch_wrap.pc", 32'(bus.pc), 32'h3FFF);
    bus.cond = 1'b0;

    op(LOAD, 14'h20);
    op(CALL, 14'h100);
    chk_pl("call1", 32'h100, 1);
    chk("call1.empty", 32'(bus.stack_empty), 0);
    op(NEXT, 14'h0);
    op(NEXT, 14'h0);
    chk("call1_next.pc", 32'(bus.pc), 32'h102);
    op(RET, 14'h0);
    chk_pl("ret1", 32'h21, 0);
    chk("ret1.empty", 32'(bus.stack_empty), 1);

    // Pushed returns: 0x22, then 0x11..0x17
    for (int i = 0; i < 8; i++) begin
      op(CALL, 14'(32'h10 + 32'(i)));
      chk_pl("nest_call", 32'h10 + 32'(i), 32'(i + 1));
    end
    chk("nest.full", 32'(bus.stack_full), 1);
    chk("nest.ovf", 32'(bus.overflow_err), 0);
    op(CALL, 14'h200);
    chk_pl("call_full", 32'h17, 8);
    chk("call_full.ovf", 32'(bus.overflow_err), 1);
    for (int k = 0; k < 8; k++) begin
      op(RET, 14'h0);
      chk_pl("nest_ret", (k < 7) ? 32'(32'h17 - k) : 32'h22, 32'(7 - k));
    end
    chk("unwind.empty", 32'(bus.stack_empty), 1);
    chk("unwind.ovf_sticky", 32'(bus.overflow_err), 1);
    bus.err_clr = 1'b1;
    op(KEEP, 14'h0);
    bus.err_clr = 1'b0;
    chk("ovf_clr", 32'(bus.overflow_err), 0);

    op(RET, 14'h0);
    chk_pl("ret_empty", 32'h22, 0);
    chk("ret_empty.udf", 32'(bus.underflow_err), 1);
    bus.err_clr = 1'b1;
    op(KEEP, 14'h0);
    chk("udf_clr", 32'(bus.underflow_err), 0);
    op(RET, 14'h0);
    chk("udf_set_wins", 32'(bus.underflow_err), 1);
    bus.err_clr = 1'b0;

    op(LOAD, 14'h3FFF);
    op(CALL, 14'h40);
    chk_pl("call_wrap", 32'h40, 1);
    op(3'd6, 14'h123);
    chk_pl("rsvd6", 32'h40, 1);
    op(3'd7, 14'h123);
    chk_pl("rsvd7", 32'h40, 1);
    op(RET, 14'h0);
    chk_pl("ret_wrap", 0, 0);

    op(LOAD, 14'h50);
    op(CALL, 14'h60);
    op(CALL, 14'h61);
    op(CALL, 14'h62);
    chk_pl("pre_rst", 32'h62, 3);
    rst = 1'b0;
    op(CALL, 14'h300);
    chk_pl("rst_mid", 0, 0);
    chk("rst_mid.udf", 32'(bus.underflow_err), 0);
    rst = 1'b1;
    op(RET, 14'h0);
    chk_pl("rst_then_ret", 0, 0);
    chk("rst_then_ret.udf", 32'(bus.underflow_err), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
